div16_seq: RTL
==============

DIV16_SEQ -- requirements
Module: div16_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operands a and b are valid this cycle.
REQ-005 in_ready  output  1  block can accept operands; equals 1 only in state IDLE.
REQ-006 a  input  16  signed product value (dividend), same fixed-point scaling as the multiplier output.
REQ-007 b  input  16  signed divisor (weight).
REQ-008 out_valid  output  1  q, sat and dz are valid; held until consumed.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 q  output  18  signed quotient, reconstructed multiplier operand.
REQ-011 sat  output  1  the quotient was saturated.
REQ-012 dz  output  1  the divisor was zero.

Function
REQ-013 Math: q SHALL equal trunc_toward_zero((a * 2^15) / b), clamped to [-131072, 131071]; this is the inverse of the 18x16 Q15 multiply.
REQ-014 Accept: an accept edge SHALL occur on a rising edge where in_valid=1 and in_ready=1.
- On the accept edge the block SHALL latch sign = a[15] XOR b[15], |a|*2^15 (31 bits), |b| (16 bits), and the zero-divisor condition.
- -32768 SHALL be handled without overflow.
REQ-015 FSM states SHALL be IDLE, CALC, FIX and HOLD.
- IDLE -> CALC on accept.
- CALC -> FIX after exactly 31 iterations.
- FIX -> HOLD after 1 cycle.
- HOLD -> IDLE on an edge where out_ready=1.
REQ-016 CALC SHALL perform one restoring shift/subtract iteration per cycle on a 5-bit counter.
- The quotient bit is produced MSB first.
- The remainder is 17 bits wide.
REQ-017 FIX SHALL apply the sign, saturate, and register q, sat, dz and out_valid=1.
REQ-018 Latency: out_valid SHALL rise after the 32nd rising edge following the accept edge, giving a fixed 32-cycle latency.
- Throughput SHALL be at most one operation per 33 cycles plus the out_ready wait.
REQ-019 Saturation:
- A magnitude above 131071 with a positive sign SHALL produce q=131071, sat=1.
- A magnitude above 131072 with a negative sign SHALL produce q=-131072, sat=1.
- A negative result of exactly 131072 SHALL produce q=-131072, sat=0.
REQ-020 Divide by zero: b=0 SHALL produce dz=1, sat=1.
- q=131071 if a>=0; q=-131072 if a<0.
- The latency SHALL be unchanged (no early exit).
REQ-021 A zero dividend (a=0, b!=0) SHALL produce q=0, sat=0, dz=0.
REQ-022 In HOLD, q, sat, dz and out_valid SHALL stay stable until out_ready=1.
- out_ready while not in HOLD SHALL be ignored.
REQ-023 in_ready SHALL be 0 in CALC, FIX and HOLD.
- in_valid in those states SHALL be ignored without corrupting the operation in progress.
- A new operand can be accepted no earlier than the cycle after out_valid falls.
REQ-024 Operand inputs a and b SHALL be sampled only on the accept edge; later changes SHALL have no effect.

Reset
REQ-025 While rst_n=0 the block SHALL hold:
- state=IDLE, in_ready=1, out_valid=0;
- q=0, sat=0, dz=0;
- counter and datapath registers cleared.
REQ-026 Reset asserted during CALC, FIX or HOLD SHALL abort the operation immediately.
- No out_valid pulse SHALL be produced for the aborted operation.
- The first accept after reset release SHALL complete normally.

Verification
REQ-027 Nominal: a=8192, b=16384, out_ready=1 -> out_valid after 32 edges, q=16384, sat=0, dz=0; then a=-8192, b=16384 -> q=-16384.
REQ-028 Truncation: a=1, b=3 -> q=10922; a=-1, b=3 -> q=-10922; a=-32768, b=-32768 -> q=32768.
REQ-029 Saturation and zero: a=16384, b=1 -> q=131071, sat=1; a=-16384, b=1 -> q=-131072, sat=1; a=-5, b=0 -> q=-131072, dz=1, sat=1, 32-cycle latency.
REQ-030 Backpressure: out_ready=0 for 10 cycles after out_valid -> q stable and in_ready=0 throughout; out_ready=1 -> out_valid low next edge and in_ready=1.
REQ-031 Reset mid-op: assert rst_n=0 at CALC iteration 12 -> out_valid=0, in_ready=1 at once; after release, a=1, b=3 -> q=10922.
REQ-032 Round-trip: 1000 random (a, b!=0) with result in range -> mul18_16(q, b) within 1 LSB of a for |b| >= 256; a scoreboard against the reference model covers every case.

Source files
------------

// File: rtl/div16_seq.sv
// div16_seq: sequential signed divider that inverts the 18x16 Q15 multiply.
// q = trunc_toward_zero(a * 2^15 / b), clamped to the 18-bit signed range.
// Magnitudes go through a 31-iteration restoring divider, and the sign is
// applied at the end.
//
// Handshake: an operand pair is taken on a rising edge with in_valid=1 and
// in_ready=1. A result is consumed on a rising edge with out_valid=1 and
// out_ready=1. After out_valid rises, q/sat/dz/out_valid stay frozen until
// that consuming edge.
module div16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] q,
  output logic        sat,
  output logic        dz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [30:0] POS_LIM = 31'd131071;
  localparam logic [30:0] NEG_LIM = 31'd131072;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        sign;
  logic        dz_r;
  logic [30:0] dvd;   // |a| * 2^15; its bits are fed into the remainder MSB first
  logic [15:0] dvs;   // |b|; -32768 becomes 32768, which still fits in 16 bits
  logic [16:0] rem;
  logic [30:0] quo;

  logic        accept;
  logic [15:0] a_mag;
  logic [15:0] b_mag;
  logic [17:0] rem_sh;
  logic        ge;
  logic [16:0] rem_sub;
  logic [17:0] q_fix;
  logic        sat_fix;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign a_mag    = a[15] ? (~a + 16'd1) : a;
  assign b_mag    = b[15] ? (~b + 16'd1) : b;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, dvd[30]};
    ge      = (rem_sh >= {2'b00, dvs});
    rem_sub = rem_sh[16:0] - {1'b0, dvs};
  end

  // Apply the sign and clamp the 31-bit magnitude into the 18-bit output range.
  always_comb begin
    q_fix   = 18'd0;
    sat_fix = 1'b0;
    if (dz_r) begin
      sat_fix = 1'b1;
      q_fix   = sign ? 18'h20000 : 18'h1FFFF;
    end else if (!sign) begin
      if (quo > POS_LIM) begin
        sat_fix = 1'b1;
        q_fix   = 18'h1FFFF;
      end else begin
        q_fix = quo[17:0];
      end
    end else begin
      if (quo > NEG_LIM) begin
        sat_fix = 1'b1;
        q_fix   = 18'h20000;
      end else begin
        // An exact magnitude of 131072 negates to 18'h20000 without saturating.
        q_fix = (~quo[17:0]) + 18'd1;
      end
    end
  end

  // Control FSM and iteration counter; CALC runs cnt 0..30, i.e. 31 steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CALC;
            cnt   <= 5'd0;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd30) state <= FIX;
        end
        FIX:     state <= HOLD;
        HOLD:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: capture operand magnitudes on accept, then iterate in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      dz_r <= 1'b0;
      dvd  <= 31'd0;
      dvs  <= 16'd0;
      rem  <= 17'd0;
      quo  <= 31'd0;
    end else if (accept) begin
      sign <= a[15] ^ b[15];
      dz_r <= (b == 16'd0);
      dvd  <= {a_mag, 15'd0};
      dvs  <= b_mag;
      rem  <= 17'd0;
      quo  <= 31'd0;
    end else if (state == CALC) begin
      dvd <= {dvd[29:0], 1'b0};
      rem <= ge ? rem_sub : rem_sh[16:0];
      quo <= {quo[29:0], ge};
    end
  end

  // Result registers: loaded in FIX, frozen through HOLD until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= 18'd0;
      sat       <= 1'b0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
    end else if (state == FIX) begin
      q         <= q_fix;
      sat       <= sat_fix;
      dz        <= dz_r;
      out_valid <= 1'b1;
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
